// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core PC sequencing logic.
// Holds the sequencer state encoding, the reset PC and the ecall cause code.
// Imported by the PC sequencer and by the next-PC select mux.
package npc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    COMMIT = 3'd3,
    HALT   = 3'd4
  } pc_state_e;

  localparam logic [31:0] RESET_PC      = 32'h8000_0000;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] PC_STEP       = 32'd4;

endpackage

// File: rtl/dnpc_sel.sv
// Next-PC select: fixed-priority mux over trap, return, jump, branch and sequential sources.
// Purely combinational, zero latency; no handshake.
// Shared by the multicycle sequencer and the single-cycle core build.
module dnpc_sel
  import npc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump_flag,
  input  logic        branch_flag,
  input  logic        is_mret,
  input  logic        is_ecall,
  input  logic [31:0] exu_res,
  input  logic [31:0] branch_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] dnpc
);

  // Priority: ecall > mret > jump > branch > pc+4; targets pass through unmasked
  always_comb begin
    dnpc = pc + PC_STEP;
    if (is_ecall) begin
      dnpc = mtvec;
    end else if (is_mret) begin
      dnpc = mepc;
    end else if (jump_flag) begin
      dnpc = exu_res;
    end else if (branch_flag) begin
      dnpc = branch_pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle PC sequencer: owns the PC and steps FETCH -> EXEC -> COMMIT per instruction.
// Minimum 3 cycles per instruction; pc updates on the edge that ends COMMIT.
// Holds in FETCH until fetch_ready, in EXEC until inst_done; ebreak parks it in HALT.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = npc_pkg::RESET_PC,
  parameter logic [31:0] ECALL_CAUSE = npc_pkg::CAUSE_ECALL_M
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  input  logic        inst_done,
  input  logic        jump_flag,
  input  logic        branch_flag,
  input  logic        is_mret,
  input  logic        is_ecall,
  input  logic        is_ebreak,
  input  logic [31:0] exu_res,
  input  logic [31:0] branch_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        commit,
  output logic        trap_we,
  output logic [31:0] trap_mepc,
  output logic [31:0] trap_mcause,
  output logic        halted
);

  import npc_pkg::*;

  pc_state_e   state;
  pc_state_e   state_nxt;
  logic [31:0] pc_q;
  logic [31:0] npc_q;
  logic        trap_q;
  logic [31:0] dnpc;
  logic        exec_done;

  // Completion is only meaningful while waiting in EXEC
  assign exec_done = (state == EXEC) && inst_done;

  dnpc_sel u_dnpc_sel (
    .pc          (pc_q),
    .jump_flag   (jump_flag),
    .branch_flag (branch_flag),
    .is_mret     (is_mret),
    .is_ecall    (is_ecall),
    .exu_res     (exu_res),
    .branch_pc   (branch_pc),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .dnpc        (dnpc)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (fetch_ready) state_nxt = EXEC;
      EXEC: begin
        if (inst_done) begin
          state_nxt = is_ebreak ? HALT : COMMIT;
        end
      end
      COMMIT:  state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the chosen next PC and trap flag at completion; PC moves only at end of COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      npc_q  <= '0;
      trap_q <= 1'b0;
    end else begin
      if (exec_done && !is_ebreak) begin
        npc_q  <= dnpc;
        trap_q <= is_ecall;
      end
      if (state == COMMIT) begin
        pc_q <= npc_q;
      end
    end
  end

  // Outputs decoded from state and registered values only; pc_q is still the ecall PC in COMMIT
  always_comb begin
    fetch_valid = (state == FETCH);
    commit      = (state == COMMIT);
    halted      = (state == HALT);
    trap_we     = (state == COMMIT) && trap_q;
    trap_mepc   = trap_we ? pc_q : '0;
    trap_mcause = trap_we ? ECALL_CAUSE : '0;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer.
// Driver plays IFU and EXU and queues the expected commit; a monitor pops on each commit pulse.
// Directed reset, priority, wrap, reset-in-COMMIT and ebreak cases surround a random run.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] CAUSE  = 32'd11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] pc;
  logic        inst_done = 1'b0;
  logic        jump_flag = 1'b0, branch_flag = 1'b0, is_mret = 1'b0;
  logic        is_ecall = 1'b0, is_ebreak = 1'b0;
  logic [31:0] exu_res = '0, branch_pc = '0, mtvec = '0, mepc = '0;
  logic        commit, trap_we, halted;
  logic [31:0] trap_mepc, trap_mcause;

  pc_sequencer dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .pc(pc),
    .inst_done(inst_done), .jump_flag(jump_flag), .branch_flag(branch_flag),
    .is_mret(is_mret), .is_ecall(is_ecall), .is_ebreak(is_ebreak),
    .exu_res(exu_res), .branch_pc(branch_pc), .mtvec(mtvec), .mepc(mepc),
    .commit(commit), .trap_we(trap_we), .trap_mepc(trap_mepc),
    .trap_mcause(trap_mcause), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] npc;
    logic        trap;
    logic [31:0] old_pc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_pc = RST_PC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Reference next PC straight from the priority list
  function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic j, b, mr, ec,
                                          input logic [31:0] er, bp, mt, me);
    if (ec) return mt;
    if (mr) return me;
    if (j)  return er;
    if (b)  return bp;
    return cur + 32'd4;
  endfunction

  task automatic junk_inputs();
    jump_flag   = 1'($urandom_range(0, 1));
    branch_flag = 1'($urandom_range(0, 1));
    is_mret     = 1'($urandom_range(0, 1));
    is_ecall    = 1'($urandom_range(0, 1));
    is_ebreak   = 1'($urandom_range(0, 1));
    exu_res     = $urandom;
    branch_pc   = $urandom;
    mtvec       = $urandom;
    mepc        = $urandom;
  endtask

  // IFU side: random ready; returns once a handshake has happened. Called #1 after an edge.
  task automatic fetch_one(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      fetch_ready = ($urandom_range(0, 3) != 0);
      // inst_done while not in EXEC must be ignored
      inst_done = ($urandom_range(0, 3) == 0);
      if (inst_done) junk_inputs();
      if (fetch_valid && fetch_ready) begin
        check("fetch_pc", pc, model_pc);
        @(posedge clk); #1;
        fetch_ready = 1'b0;
        inst_done   = 1'b0;
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    inst_done = 1'b0;
  endtask

  // One instruction: fetch, wait some EXEC cycles, then complete with the given flags
  task automatic run_instr(input logic a_j, a_b, a_mr, a_ec, a_eb,
                           input logic [31:0] a_er, a_bp, a_mt, a_me,
                           input int delay, input bit expect_commit);
    bit   ok;
    exp_t e;
    fetch_one(ok);
    if (!ok) begin
      check("fetch_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (delay) begin
      fetch_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    jump_flag = a_j; branch_flag = a_b; is_mret = a_mr; is_ecall = a_ec; is_ebreak = a_eb;
    exu_res = a_er; branch_pc = a_bp; mtvec = a_mt; mepc = a_me;
    inst_done = 1'b1;
    if (!a_eb && expect_commit) begin
      e.npc    = ref_npc(model_pc, a_j, a_b, a_mr, a_ec, a_er, a_bp, a_mt, a_me);
      e.trap   = a_ec;
      e.old_pc = model_pc;
      exp_q.push_back(e);
      model_pc = e.npc;
    end
    @(posedge clk); #1;
    inst_done = 1'b0;
    junk_inputs();
  endtask

  task automatic reset_release();
    rst = 1'b0;
    model_pc = RST_PC;
    check("idle_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    @(posedge clk); #1;
    check("first_fetch_valid", {31'd0, fetch_valid}, 32'd1);
    check("first_fetch_pc", pc, RST_PC);
  endtask

  // Monitor: pops on every commit pulse, then checks the PC written at that edge
  logic        pend_vld = 1'b0;
  logic [31:0] pend_pc;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend_vld) begin
        check("commit_pc", pc, pend_pc);
        pend_vld = 1'b0;
      end
      if (commit) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("commit_old_pc", pc, e.old_pc);
          check("trap_we", {31'd0, trap_we}, {31'd0, e.trap});
          check("trap_mepc", trap_mepc, e.trap ? e.old_pc : 32'd0);
          check("trap_mcause", trap_mcause, e.trap ? CAUSE : 32'd0);
          pend_vld = 1'b1;
          pend_pc  = e.npc;
        end
      end else if (trap_we) begin
        check("trap_we_without_commit", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] frozen;
    logic [31:0] tgt;
    bit          ok;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_commit", {31'd0, commit}, 32'd0);
    check("rst_trap_we", {31'd0, trap_we}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_trap_mepc", trap_mepc, 32'd0);
    check("rst_trap_mcause", trap_mcause, 32'd0);
    reset_release();

    // Fetch held off: request and PC must stay put
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_fetch_valid", {31'd0, fetch_valid}, 32'd1);
      check("hold_pc", pc, RST_PC);
    end

    // Sequential, jump-over-branch, ecall-over-all, mret
    run_instr(0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 1);
    run_instr(1, 1, 0, 0, 0, 32'h8000_0100, 32'h8000_0200, '0, '0, 0, 1);
    run_instr(1, 1, 0, 1, 0, 32'h8000_0100, 32'h8000_0200, 32'h8000_1000, '0, 1, 1);
    run_instr(0, 0, 1, 0, 0, '0, '0, '0, 32'h8000_0040, 2, 1);
    // Wrap from the top of the address space
    run_instr(1, 0, 0, 0, 0, 32'hFFFF_FFFC, '0, '0, '0, 0, 1);
    run_instr(0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 1);

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      run_instr(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), 1'b0,
                tgt, $urandom, $urandom, $urandom, $urandom_range(0, 3), 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    // Reset lands in COMMIT of an ecall: no pulse survives, PC returns to reset value
    fetch_one(ok);
    if (!ok) check("fetch_timeout", 32'd0, 32'd1);
    jump_flag = 1'b1; is_ecall = 1'b1; is_ebreak = 1'b0; mtvec = 32'h1234_5678;
    inst_done = 1'b1;
    @(posedge clk); #1;
    inst_done = 1'b0;
    check("pre_rst_commit", {31'd0, commit}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_commit_abort", {31'd0, commit}, 32'd0);
    check("rst_trap_abort", {31'd0, trap_we}, 32'd0);
    check("rst_pc_async", pc, RST_PC);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_pc", pc, RST_PC);
    reset_release();
    run_instr(0, 1, 0, 0, 0, '0, 32'h8000_0300, '0, '0, 0, 1);
    run_instr(0, 0, 0, 0, 0, '0, '0, '0, '0, 1, 1);

    // ebreak: halt with no commit, then ignore everything
    run_instr(1, 0, 0, 1, 1, 32'h1, 32'h2, 32'h3, 32'h4, 1, 0);
    check("halted", {31'd0, halted}, 32'd1);
    check("halt_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("halt_commit", {31'd0, commit}, 32'd0);
    frozen = pc;
    check("halt_pc", frozen, model_pc);
    repeat (6) begin
      fetch_ready = 1'b1;
      inst_done   = 1'b1;
      junk_inputs();
      @(posedge clk); #1;
      check("halt_stays", {31'd0, halted}, 32'd1);
      check("halt_no_fetch", {31'd0, fetch_valid}, 32'd0);
      check("halt_pc_frozen", pc, frozen);
    end
    inst_done = 1'b0;
    fetch_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle PC sequencer for the NPC core. It owns the architectural PC register and runs one instruction at a time through fetch, execute and commit. At commit it chooses the next PC from the ecall/mret/jump/branch/sequential sources and writes the trap CSRs on ecall. It sits between the IFU handshake and the EXU/WBU completion signal and replaces free-running PC updates.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- ECALL_CAUSE, 32'd11, mcause value written on ecall (M-mode environment call)

- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- fetch_valid  out  1  fetch request to IFU at address pc
- fetch_ready  in  1  IFU accepts the request
- pc  out  32  current architectural PC
- inst_done  in  1  single-cycle pulse: EXU/WBU finished; flags and targets are valid this cycle
- jump_flag, branch_flag, is_mret, is_ecall, is_ebreak  in  1 each  control flags, qualified by inst_done
- exu_res, branch_pc, mtvec, mepc  in  32 each  candidate targets, qualified by inst_done
- commit  out  1  one-cycle pulse when pc updates
- trap_we  out  1  one-cycle pulse: write mepc and mcause
- trap_mepc  out  32  value for mepc (PC of the ecall)
- trap_mcause  out  32  value for mcause (ECALL_CAUSE)
- halted  out  1  core stopped by ebreak

## Operation
- States: IDLE, FETCH, EXEC, COMMIT, HALT.
- IDLE: entered on reset. Goes to FETCH unconditionally on the next clk.
- FETCH: fetch_valid=1. Holds until fetch_ready=1, then goes to EXEC. fetch_valid must not drop before acceptance, and pc is stable throughout.
- EXEC: waits for inst_done.
  - If inst_done and is_ebreak: go to HALT.
  - Else: latch npc_q and trap_q, then go to COMMIT.
  - inst_done outside EXEC is ignored.
- Next-PC priority (highest first): is_ecall→mtvec; is_mret→mepc; jump_flag→exu_res; branch_flag→branch_pc; otherwise pc+4 (modulo 2^32).
- Several flags asserted together resolve by this priority. Targets are used verbatim, with no alignment masking.
- COMMIT: pc←npc_q and commit=1. If trap_q, then trap_we=1, trap_mepc=old pc, trap_mcause=ECALL_CAUSE. Goes to FETCH.
- HALT: terminal. halted=1, fetch_valid=0, pc frozen. Only rst exits.

## Timing
- Reset values: pc=RESET_PC, state=IDLE. fetch_valid, commit, trap_we and halted are all 0. trap_mepc and trap_mcause are 0.
- rst asserted in any state (including mid-handshake or in COMMIT) aborts immediately. Latched npc_q/trap_q are discarded and no commit or trap_we is emitted.
- First fetch_valid appears 1 cycle after rst deasserts (IDLE→FETCH).
- Minimum instruction period is 3 cycles: FETCH with ready at first cycle, EXEC with inst_done at first cycle, then COMMIT.
- All outputs are registered or decoded from state only. No combinational path runs from inputs to outputs.
- pc changes only on the clk edge ending COMMIT. commit and trap_we are high in the same single cycle.

## Structure
- Shared package npc_pkg holds:
  - pc_state_e enum (IDLE, FETCH, EXEC, COMMIT, HALT)
  - RESET_PC default
  - CAUSE_ECALL_M = 11
- Sub-module dnpc_sel: the combinational priority mux from flags/targets/pc to the next PC. It is also reused by the single-cycle build.
- The top-level pc_sequencer contains the FSM, pc register, npc_q and trap_q latches, and the output register logic.

## Test plan
- Reset release → pc=0x8000_0000, fetch_valid=1 exactly one cycle after rst falls. fetch_ready held 0 for 5 cycles → fetch_valid stays 1 and pc is unchanged.
- Sequential: inst_done with no flags at pc=0x8000_0000 → commit pulse, pc=0x8000_0004, trap_we=0.
- Priority: inst_done with jump_flag=1, branch_flag=1, exu_res=0x8000_0100, branch_pc=0x8000_0200 → pc=0x8000_0100. Same cycle with is_ecall also set and mtvec=0x8000_1000 → pc=0x8000_1000, trap_we=1, trap_mepc=old pc, trap_mcause=11.
- mret with mepc=0x8000_0040 → pc=0x8000_0040, trap_we=0. Wrap: pc=0xFFFF_FFFC with no flags → pc=0x0000_0000.
- ebreak: inst_done with is_ebreak → halted=1, fetch_valid=0, no commit pulse. Further inst_done/fetch_ready are ignored.
- rst asserted in the COMMIT cycle → no commit/trap_we pulse observed, pc=0x8000_0000 asynchronously. Recovery follows the reset sequence.
